// File: rtl/nibble_serial_alu_pkg.sv
// Shared opcodes, FSM encoding and slice width for the nibble-serial ALU.
package nibble_serial_alu_pkg;

  localparam int unsigned NIBBLE = 4;

  localparam logic [2:0] OP_CLR   = 3'b000;
  localparam logic [2:0] OP_BSUBA = 3'b001;
  localparam logic [2:0] OP_ASUBB = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_SET   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the ops that use the carry chain.
  function automatic logic is_arith(input logic [2:0] sel);
    return (sel == OP_BSUBA) || (sel == OP_ASUBB) || (sel == OP_ADD);
  endfunction

endpackage

// File: rtl/nibble_serial_alu_if.sv
// Request/response bundle between the datapath sequencer and the serial ALU.
interface nibble_serial_alu_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [2:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sel, a, b, c_in,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, sel, a, b, c_in,
    output busy, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/nibble_serial_alu_nibble.sv
// Combinational 4-bit ALU slice with group generate/propagate outputs.
module nibble_serial_alu_nibble
  import nibble_serial_alu_pkg::*;
(
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic [2:0] sel,
  input  logic       c,
  output logic [3:0] f4,
  output logic       g,
  output logic       p,
  output logic       c_msb
);

  logic [3:0] x, y, gi, pi, sum4, lo;
  logic       arith;

  // Operand conditioning, sum and carry-lookahead terms for one nibble.
  always_comb begin
    x     = a4;
    y     = b4;
    arith = is_arith(sel);
    f4    = 4'h0;
    g     = 1'b0;
    p     = 1'b0;
    c_msb = 1'b0;
    if (sel == OP_BSUBA) x = ~a4;
    if (sel == OP_ASUBB) y = ~b4;
    gi   = x & y;
    pi   = x ^ y;
    sum4 = x + y + {3'b000, c};
    lo   = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, c};
    if (arith) begin
      f4    = sum4;
      g     = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (&pi[3:1] & gi[0]);
      p     = &pi;
      c_msb = lo[3];
    end else begin
      case (sel)
        OP_XOR:  f4 = a4 ^ b4;
        OP_OR:   f4 = a4 | b4;
        OP_AND:  f4 = a4 & b4;
        OP_SET:  f4 = 4'hF;
        default: f4 = 4'h0;
      endcase
    end
  end

endmodule

// File: rtl/nibble_serial_alu.sv
// WIDTH-bit ALU that reuses one nibble slice, LSB nibble first, with start/busy/done handshake.
module nibble_serial_alu
  import nibble_serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  nibble_serial_alu_if.slave  bus
);

  localparam int unsigned NIB = WIDTH / NIBBLE;
  localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state, state_n;
  logic [KW-1:0]      k;
  logic               carry;
  logic [2:0]         sel_q;
  logic [WIDTH-1:0]   a_q, b_q, shadow;
  logic [3:0]         f4;
  logic               g, p, c_msb, c_next, last, accept;
  logic [WIDTH+NIBBLE-1:0] asm_c;
  logic [WIDTH-1:0]   res_c;

  nibble_serial_alu_nibble u_slice (
    .a4    (a_q[3:0]),
    .b4    (b_q[3:0]),
    .sel   (sel_q),
    .c     (carry),
    .f4    (f4),
    .g     (g),
    .p     (p),
    .c_msb (c_msb)
  );

  assign c_next = g | (p & carry);
  assign last   = (k == KW'(NIB - 1));
  assign accept = (state != ST_RUN) && bus.start;
  assign asm_c  = {f4, shadow};
  assign res_c  = asm_c[WIDTH+NIBBLE-1:NIBBLE];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (bus.start) state_n = ST_RUN;
      ST_RUN:  if (last)      state_n = ST_DONE;
      ST_DONE: state_n = bus.start ? ST_RUN : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Operand latch, nibble shifting, carry chain and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k             <= '0;
      carry         <= 1'b0;
      sel_q         <= OP_CLR;
      a_q           <= '0;
      b_q           <= '0;
      shadow        <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b1;
    end else begin
      bus.busy <= (state_n == ST_RUN);
      bus.done <= (state_n == ST_DONE);
      if (accept) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        sel_q <= bus.sel;
        k     <= '0;
        if (bus.sel == OP_ADD)      carry <= bus.c_in;
        else if (is_arith(bus.sel)) carry <= 1'b1;
        else                        carry <= 1'b0;
      end else if (state == ST_RUN) begin
        a_q    <= a_q >> NIBBLE;
        b_q    <= b_q >> NIBBLE;
        shadow <= res_c;
        carry  <= c_next;
        k      <= k + KW'(1);
        if (last) begin
          bus.result    <= res_c;
          bus.carry_out <= is_arith(sel_q) ? c_next : 1'b0;
          bus.overflow  <= is_arith(sel_q) ? (c_msb ^ c_next) : 1'b0;
          bus.zero      <= (res_c == '0);
        end
      end
    end
  end

endmodule
